// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit packed-BCD up/down counter with synchronous
// clear, parallel load, wrap/saturate at the terminal values, a registered
// CARRY/BORROW pulse and a combinational TC output for cascading stages.
// Optional build macro BCD_LOAD_CHECK_EN rejects loads that carry a non-BCD
// digit and raises ERR. When the macro is undefined, loads are accepted
// verbatim and ERR is tied low.
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  EN,
  input  logic                  UP,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  CARRY,
  output logic                  BORROW,
  output logic                  TC,
  output logic                  ZERO,
  output logic                  ERR
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] nines;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         inc_cout;
  logic         dec_bout;
  logic         inc_c;
  logic         dec_b;
  logic [3:0]   inc_d;
  logic [3:0]   dec_d;
  logic [W-1:0] bcd_nxt;
  logic         carry_nxt;
  logic         borrow_nxt;

  // Constant all-nines pattern used for the up-terminal compare.
  always_comb begin
    nines = '0;
    for (int i = 0; i < DIGITS; i++) nines[4*i +: 4] = 4'h9;
  end

  // Up ripple: any digit >= 9 that receives a carry rolls to 0 and passes it on.
  always_comb begin
    inc_val = '0;
    inc_c   = 1'b1;
    inc_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc_d = BCD[4*i +: 4];
      if (!inc_c) begin
        inc_val[4*i +: 4] = inc_d;
      end else if (inc_d >= 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
        inc_c             = 1'b1;
      end else begin
        inc_val[4*i +: 4] = inc_d + 4'd1;
        inc_c             = 1'b0;
      end
    end
    inc_cout = inc_c;
  end

  // Down ripple: 0 borrows and becomes 9; a non-BCD digit snaps to 9 without borrowing.
  always_comb begin
    dec_val = '0;
    dec_b   = 1'b1;
    dec_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dec_d = BCD[4*i +: 4];
      if (!dec_b) begin
        dec_val[4*i +: 4] = dec_d;
      end else if (dec_d == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
        dec_b             = 1'b1;
      end else if (dec_d > 4'd9) begin
        dec_val[4*i +: 4] = 4'd9;
        dec_b             = 1'b0;
      end else begin
        dec_val[4*i +: 4] = dec_d - 4'd1;
        dec_b             = 1'b0;
      end
    end
    dec_bout = dec_b;
  end

`ifdef BCD_LOAD_CHECK_EN
  logic load_bad;
  logic err_nxt;

  // Flag a load value containing any digit above 9.
  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (LOAD_VAL[4*i +: 4] > 4'd9) load_bad = 1'b1;
  end
`endif

  // Next-state selection: CLR > LOAD > EN > hold; pulses default low every edge.
  always_comb begin
    bcd_nxt    = BCD;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
`ifdef BCD_LOAD_CHECK_EN
    err_nxt    = ERR;
`endif
    if (CLR) begin
      bcd_nxt = '0;
`ifdef BCD_LOAD_CHECK_EN
      err_nxt = 1'b0;
`endif
    end else if (LOAD) begin
`ifdef BCD_LOAD_CHECK_EN
      if (load_bad) begin
        err_nxt = 1'b1;
      end else begin
        bcd_nxt = LOAD_VAL;
        err_nxt = 1'b0;
      end
`else
      bcd_nxt = LOAD_VAL;
`endif
    end else if (EN) begin
      if (UP) begin
        if (!inc_cout) begin
          bcd_nxt = inc_val;
        end else if (WRAP) begin
          bcd_nxt   = inc_val;
          carry_nxt = 1'b1;
        end
      end else begin
        if (!dec_bout) begin
          bcd_nxt = dec_val;
        end else if (WRAP) begin
          bcd_nxt    = dec_val;
          borrow_nxt = 1'b1;
        end
      end
    end
  end

  // Count and pulse registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      BCD    <= '0;
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
    end else begin
      BCD    <= bcd_nxt;
      CARRY  <= carry_nxt;
      BORROW <= borrow_nxt;
    end
  end

`ifdef BCD_LOAD_CHECK_EN
  // Sticky load-error flag, cleared by CLR or a valid LOAD.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) ERR <= 1'b0;
    else       ERR <= err_nxt;
  end
`else
  assign ERR = 1'b0;
`endif

  assign TC   = EN & ((UP & (BCD == nines)) | (~UP & (BCD == '0)));
  assign ZERO = (BCD == '0);

endmodule
